// File: rtl/soc_system_switch_debounce.sv
// soc_system_switch_debounce: two-flop synchronizer plus per-bit debounce with registered rise/fall/change pulses.
module soc_system_switch_debounce #(
    parameter int               WIDTH           = 3,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}},
    parameter int               CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_clean,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);
    logic [WIDTH-1:0] r_s1, r_s2, r_clean, r_rise, r_fall;
    logic             r_any;
    logic [WIDTH-1:0] w_mismatch, w_accept;

    assign w_mismatch = r_s2 ^ r_clean;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            logic [CNT_W-1:0] r_cnt;
            assign w_accept[g] = w_mismatch[g] && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
            // Any agreement with the clean level, or an accept, restarts the interval.
            always_ff @(posedge clk) begin
                if (reset || !w_mismatch[g] || w_accept[g])
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= RESET_VALUE;
            r_s2    <= RESET_VALUE;
            r_clean <= RESET_VALUE;
            r_rise  <= '0;
            r_fall  <= '0;
            r_any   <= 1'b0;
        end else begin
            r_s1    <= switch_raw;
            r_s2    <= r_s1;
            r_clean <= r_clean ^ w_accept;
            r_rise  <= w_accept & r_s2;
            r_fall  <= w_accept & ~r_s2;
            r_any   <= |w_accept;
        end
    end

    assign switch_clean = r_clean;
    assign rise_pulse   = r_rise;
    assign fall_pulse   = r_fall;
    assign any_change   = r_any;
endmodule

// File: tb/tb_soc_system_switch_debounce.sv
// tb_soc_system_switch_debounce: table-driven per-cycle vectors checked through a scoreboard queue.
module tb_soc_system_switch_debounce;
    typedef struct packed {
        logic       rst;
        logic [2:0] raw;
        logic [2:0] clean;
        logic [2:0] rise;
        logic [2:0] fall;
        logic       chg;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] switch_raw = 3'b000;
    logic [2:0] switch_clean, rise_pulse, fall_pulse;
    logic       any_change;
    vec_t       vecs[$];
    vec_t       sb[$];
    vec_t       e;
    int         checks = 0;
    int         passed = 0;
    int         n;

    always #5 clk = ~clk;

    soc_system_switch_debounce #(
        .WIDTH(3),
        .DEBOUNCE_CYCLES(4),
        .RESET_VALUE(3'b000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .switch_raw(switch_raw),
        .switch_clean(switch_clean),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_change(any_change)
    );

    task automatic rep(input int cnt, input logic r, input logic [2:0] raw, input logic [2:0] clean,
                       input logic [2:0] rise, input logic [2:0] fall, input logic chg);
        vec_t v;
        v = '{rst: r, raw: raw, clean: clean, rise: rise, fall: fall, chg: chg};
        repeat (cnt) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    initial begin
        // reset with switches on, then release and return to zero
        rep(3, 1, 3'b111, 3'b000, 3'b000, 3'b000, 0);
        rep(5, 0, 3'b111, 3'b000, 3'b000, 3'b000, 0);
        rep(1, 0, 3'b111, 3'b111, 3'b111, 3'b000, 1);
        rep(2, 0, 3'b111, 3'b111, 3'b000, 3'b000, 0);
        rep(5, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0);
        rep(1, 0, 3'b000, 3'b000, 3'b000, 3'b111, 1);
        rep(2, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        // clean step on bit0
        rep(5, 0, 3'b001, 3'b000, 3'b000, 3'b000, 0);
        rep(1, 0, 3'b001, 3'b001, 3'b001, 3'b000, 1);
        rep(2, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0);
        rep(5, 0, 3'b000, 3'b001, 3'b000, 3'b000, 0);
        rep(1, 0, 3'b000, 3'b000, 3'b000, 3'b001, 1);
        rep(2, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        // 3-cycle glitch on bit1
        rep(3, 0, 3'b010, 3'b000, 3'b000, 3'b000, 0);
        rep(6, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        // bounce on bit2, settling high
        for (int k = 0; k < 2; k++) begin
            rep(2, 0, 3'b100, 3'b000, 3'b000, 3'b000, 0);
            rep(2, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        end
        rep(5, 0, 3'b100, 3'b000, 3'b000, 3'b000, 0);
        rep(1, 0, 3'b100, 3'b100, 3'b100, 3'b000, 1);
        rep(2, 0, 3'b100, 3'b100, 3'b000, 3'b000, 0);
        rep(5, 0, 3'b000, 3'b100, 3'b000, 3'b000, 0);
        rep(1, 0, 3'b000, 3'b000, 3'b000, 3'b100, 1);
        rep(2, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        // simultaneous rise and fall from 001 to 100
        rep(5, 0, 3'b001, 3'b000, 3'b000, 3'b000, 0);
        rep(1, 0, 3'b001, 3'b001, 3'b001, 3'b000, 1);
        rep(2, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0);
        rep(5, 0, 3'b100, 3'b001, 3'b000, 3'b000, 0);
        rep(1, 0, 3'b100, 3'b100, 3'b100, 3'b001, 1);
        rep(2, 0, 3'b100, 3'b100, 3'b000, 3'b000, 0);
        rep(5, 0, 3'b000, 3'b100, 3'b000, 3'b000, 0);
        rep(1, 0, 3'b000, 3'b000, 3'b000, 3'b100, 1);
        rep(2, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
        // reset mid-count: partial count discarded
        rep(4, 0, 3'b001, 3'b000, 3'b000, 3'b000, 0);
        rep(1, 1, 3'b001, 3'b000, 3'b000, 3'b000, 0);
        rep(5, 0, 3'b001, 3'b000, 3'b000, 3'b000, 0);
        rep(1, 0, 3'b001, 3'b001, 3'b001, 3'b000, 1);
        rep(2, 0, 3'b001, 3'b001, 3'b000, 3'b000, 0);
        // reset clears an accepted level
        rep(2, 1, 3'b000, 3'b000, 3'b000, 3'b000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            switch_raw = vecs[i].raw;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d", i),
                  {6'd0, switch_clean, rise_pulse, fall_pulse, any_change},
                  {6'd0, e.clean, e.rise, e.fall, e.chg});
        end

        // bounded wait for a single bit1 accept; the capture edge counts as 1
        @(negedge clk);
        reset = 1'b0;
        switch_raw = 3'b010;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!any_change && n < 20);
        check("latency", 16'(n), 16'd6);
        check("step_rise", {13'd0, rise_pulse}, 16'h0002);
        check("step_fall", {13'd0, fall_pulse}, 16'h0000);
        check("step_clean", {13'd0, switch_clean}, 16'h0002);
        @(posedge clk);
        #1;
        check("pulse_drop", {12'd0, rise_pulse, any_change}, 16'h0000);
        check("level_hold", {13'd0, switch_clean}, 16'h0002);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
